imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction-memory interface: the CPU core only reads instruction memory.
//  Receives a program as a valid/ready byte stream and assembles little-endian 32-bit words.
//  Writes each word into instruction memory, then verifies a trailing 32-bit checksum.
//  Drives start_o, which feeds the CPU start_i: the core runs only after a clean load.
// PARAMETERS
//  ADDR_W     8     word-address width; max program = 2**ADDR_W words
//  BASE_ADDR  0     byte address of the first word written (word aligned)
//  TIMEOUT    1024  max idle cycles between accepted bytes before abort
// PORTS
//  clk_i         in   1       clock, rising edge
//  rst_i         in   1       asynchronous, active-high reset
//  load_req_i    in   1       1-cycle request to begin a load; sampled only in IDLE/DONE/ERR
//  len_i         in   ADDR_W+1  word count of the program, sampled with load_req_i
//  byte_valid_i  in   1       byte_i is valid
//  byte_i        in   8       stream byte
//  byte_ready_o  out  1       loader accepts byte_i this cycle
//  imem_we_o     out  1       instruction-memory write strobe (1 cycle per word)
//  imem_addr_o   out  32      byte address of the write
//  imem_wdata_o  out  32      word to write
//  busy_o        out  1       load in progress (RECV/WRITE/CSUM)
//  done_o        out  1       last load completed with a good checksum
//  err_o         out  1       last load failed (length, checksum or timeout)
//  start_o       out  1       run enable to the CPU start_i; equals done_o
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters/sum cleared; asynchronous, mid-load included.
//   Words already written stay in memory; start_o=0 holds the CPU.
//  All outputs are registered. A byte is accepted on a clock edge with byte_valid_i & byte_ready_o.
//  IDLE/DONE/ERR: byte_ready_o=0. On load_req_i:
//   len_i==0 or len_i>2**ADDR_W -> ERR.
//   Otherwise latch len, idx=0, lane=0, sum=0, clear done_o/err_o/start_o -> RECV.
//  RECV: byte_ready_o=1. Accepted byte goes to lane (0 -> [7:0] .. 3 -> [31:24]); lane++.
//   The 4th byte -> WRITE.
//  WRITE (1 cycle): byte_ready_o=0, imem_we_o=1.
//   imem_addr_o = BASE_ADDR + 4*idx, imem_wdata_o = assembled word.
//   sum = sum + word (mod 2**32); idx++.
//   Last word -> CSUM, else RECV. Throughput: 5 cycles/word with a continuous stream.
//  CSUM: receive 4 bytes as in RECV, with no memory write.
//   On the 4th byte compare {byte_i, bytes[23:0]} with sum.
//   Equal -> DONE (done_o=1, start_o=1 next cycle); else -> ERR (err_o=1).
//  Timeout: idle counter clears on each accepted byte and on entry to RECV.
//   In RECV/CSUM it reaches TIMEOUT -> ERR.
//  load_req_i is ignored while busy_o=1. byte_valid_i outside RECV/CSUM is ignored (not consumed).
//  A new load_req_i in DONE/ERR drops start_o/done_o/err_o on the next edge.
//  imem_addr_o/imem_wdata_o hold their last values when imem_we_o=0.
// TESTING
//  T1 len=2, bytes 13 00 50 00 93 00 10 00 A6 00 60 00 ->
//     write @0x0=0x00500013, then @0x4=0x00100093; done_o=start_o=1; err_o=0.
//  T2 as T1 but checksum byte0=A7 -> both writes occur; err_o=1, start_o=0, done_o=0.
//  T3 len=0 -> err_o=1 one cycle after the request, no writes.
//     len=257 (ADDR_W=8) -> err_o=1. len=256 is accepted.
//  T4 send 2 bytes then stall TIMEOUT cycles -> err_o=1, busy_o=0, byte_ready_o=0.
//     New load_req_i then loads cleanly.
//  T5 assert rst_i asynchronously mid-RECV -> all outputs 0 immediately, without a clock edge.
//     Next load writes from BASE_ADDR, idx 0.
//  T6 continuous byte_valid_i=1; load_req_i pulsed in RECV -> ignored.
//     byte_ready_o low exactly on WRITE cycles; imem_we_o pulses every 5 cycles.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction memory as little-endian
// 32-bit words, verifies a trailing 32-bit checksum and releases the CPU
// (start_o) only after a clean load.
module imem_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_req_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [31:0]       imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              start_o
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  // Largest legal program length: exactly 2**ADDR_W words.
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CSUM  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [1:0]          lane_q, lane_d;
  logic [23:0]         word_q, word_d;   // lower three bytes; the 4th comes straight from byte_i
  logic [31:0]         sum_q, sum_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept_s;
  logic [31:0]         full_word_s;
  logic [31:0]         idx_ext_s;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    word_d      = word_q;
    sum_d       = sum_q;
    idle_d      = idle_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    accept_s    = byte_valid_i & ready_q;
    full_word_s = {byte_i, word_q};
    idx_ext_s   = 32'(idx_q);

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (load_req_i) begin
          if ((len_i == {(ADDR_W+1){1'b0}}) || (len_i > MAX_LEN)) begin
            state_d = S_ERR;
          end else begin
            len_d   = len_i;
            idx_d   = {(ADDR_W+1){1'b0}};
            lane_d  = 2'd0;
            sum_d   = 32'd0;
            idle_d  = {IDLE_W{1'b0}};
            state_d = S_RECV;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_RECV, S_CSUM: begin
        if (accept_s) begin
          idle_d = {IDLE_W{1'b0}};
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0:    word_d[7:0]   = byte_i;
            2'd1:    word_d[15:8]  = byte_i;
            2'd2:    word_d[23:16] = byte_i;
            default: word_d        = word_q;
          endcase
          if (lane_q == 2'd3) begin
            if (state_q == S_RECV) begin
              state_d = S_WRITE;
              addr_d  = BASE_ADDR + {idx_ext_s[29:0], 2'b00};
              wdata_d = full_word_s;
            end else begin
              state_d = (full_word_s == sum_q) ? S_DONE : S_ERR;
            end
          end else begin
            state_d = state_q;
          end
        end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
          // This idle cycle would make TIMEOUT in a row: abort.
          state_d = S_ERR;
        end else begin
          idle_d = idle_q + {{(IDLE_W-1){1'b0}}, 1'b1};
        end
      end
      S_WRITE: begin
        sum_d  = sum_q + wdata_q;
        idx_d  = idx_q + {{ADDR_W{1'b0}}, 1'b1};
        idle_d = {IDLE_W{1'b0}};
        if (idx_q == (len_q - {{ADDR_W{1'b0}}, 1'b1})) begin
          state_d = S_CSUM;
        end else begin
          state_d = S_RECV;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    ready_d = (state_d == S_RECV) || (state_d == S_CSUM);
    we_d    = (state_d == S_WRITE);
    busy_d  = (state_d == S_RECV) || (state_d == S_WRITE) || (state_d == S_CSUM);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      len_q   <= {(ADDR_W+1){1'b0}};
      idx_q   <= {(ADDR_W+1){1'b0}};
      lane_q  <= 2'd0;
      word_q  <= 24'd0;
      sum_q   <= 32'd0;
      idle_q  <= {IDLE_W{1'b0}};
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      sum_q   <= sum_d;
      idle_q  <= idle_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign byte_ready_o = ready_q;
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign start_o      = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed spec scenarios plus randomized
// loads checked against a word-level model (address = base + 4*i, data = word,
// result = checksum equals the 32-bit sum of the words).
module tb_imem_loader;

  localparam int          ADDR_W = 8;
  localparam int          LW     = ADDR_W + 1;
  localparam logic [31:0] BASE   = 32'h0000_0040;
  localparam int          TMO    = 16;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              load_req_i = 1'b0;
  logic [ADDR_W:0]   len_i = '0;
  logic              byte_valid_i = 1'b0;
  logic [7:0]        byte_i = 8'h00;
  logic              byte_ready_o, imem_we_o, busy_o, done_o, err_o, start_o;
  logic [31:0]       imem_addr_o, imem_wdata_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] prog_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .load_req_i(load_req_i), .len_i(len_i),
    .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(byte_ready_o),
    .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .start_o(start_o)
  );

  always #5 clk_i = ~clk_i;

  // Record every memory write seen by the bench.
  always @(negedge clk_i) begin
    if (imem_we_o) begin
      wr_addr_q.push_back(imem_addr_o);
      wr_data_q.push_back(imem_wdata_o);
    end
  end

  function automatic logic [31:0] prog_sum();
    logic [31:0] s = 32'd0;
    foreach (prog_q[i]) s = s + prog_q[i];
    return s;
  endfunction

  task automatic request(input logic [ADDR_W:0] len);
    load_req_i = 1'b1;
    len_i      = len;
    @(negedge clk_i);
    load_req_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid_i = 1'b0;
    repeat (gap) @(negedge clk_i);
    byte_valid_i = 1'b1;
    byte_i = b;
    n = 0;
    while (!byte_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (byte_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL handshake: byte_ready_o=%0b, expected 1", byte_ready_o);
    end
    @(negedge clk_i);
    byte_valid_i = 1'b0;
  endtask

  task automatic load_prog(input logic [31:0] csum, input int max_gap);
    int n;
    logic [31:0] w;
    wr_addr_q.delete();
    wr_data_q.delete();
    request(LW'(prog_q.size()));
    foreach (prog_q[i]) begin
      w = prog_q[i];
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], $urandom_range(0, max_gap));
    end
    for (int b = 0; b < 4; b++) send_byte(csum[8*b +: 8], $urandom_range(0, max_gap));
    n = 0;
    while (!(done_o || err_o) && n < 50) begin
      @(negedge clk_i);
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    checks++;
    if ({byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, busy_o, done_o, err_o, start_o} !== 70'd0) begin
      errors++;
      $display("FAIL reset_hold: outputs not all zero (busy=%0b done=%0b err=%0b)", busy_o, done_o, err_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({byte_ready_o, imem_we_o, busy_o, done_o, err_o, start_o} !== 6'd0) begin
      errors++;
      $display("FAIL reset_idle: flags=%06b expected 000000",
               {byte_ready_o, imem_we_o, busy_o, done_o, err_o, start_o});
    end
  endtask

  task automatic test_t1_good();
    prog_q = {32'h0050_0013, 32'h0010_0093};
    load_prog(32'h0060_00A6, 0);
    checks++;
    if (wr_addr_q.size() != 2) begin
      errors++;
      $display("FAIL t1_nwrites: got %0d expected 2", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== BASE || wr_data_q[0] !== 32'h0050_0013) begin
        errors++;
        $display("FAIL t1_w0: got @%h=%h expected @%h=00500013", wr_addr_q[0], wr_data_q[0], BASE);
      end
      checks++;
      if (wr_addr_q[1] !== BASE + 32'd4 || wr_data_q[1] !== 32'h0010_0093) begin
        errors++;
        $display("FAIL t1_w1: got @%h=%h expected @%h=00100093", wr_addr_q[1], wr_data_q[1], BASE + 32'd4);
      end
    end
    checks++;
    if ({done_o, start_o, err_o, busy_o} !== 4'b1100) begin
      errors++;
      $display("FAIL t1_status: done/start/err/busy=%04b expected 1100", {done_o, start_o, err_o, busy_o});
    end
  endtask

  task automatic test_t2_bad_csum();
    prog_q = {32'h0050_0013, 32'h0010_0093};
    load_prog(32'h0060_00A7, 1);
    checks++;
    if (wr_addr_q.size() != 2) begin
      errors++;
      $display("FAIL t2_nwrites: got %0d expected 2", wr_addr_q.size());
    end
    checks++;
    if ({done_o, start_o, err_o, busy_o} !== 4'b0010) begin
      errors++;
      $display("FAIL t2_status: done/start/err/busy=%04b expected 0010", {done_o, start_o, err_o, busy_o});
    end
  endtask

  task automatic test_len();
    wr_addr_q.delete();
    wr_data_q.delete();
    request(LW'(0));
    checks++;
    if ({err_o, busy_o, done_o} !== 3'b100 || wr_addr_q.size() != 0) begin
      errors++;
      $display("FAIL len0: err/busy/done=%03b writes=%0d expected 100 and 0", {err_o, busy_o, done_o}, wr_addr_q.size());
    end
    request(LW'(257));
    checks++;
    if ({err_o, busy_o} !== 2'b10) begin
      errors++;
      $display("FAIL len257: err/busy=%02b expected 10", {err_o, busy_o});
    end
    // Maximum length is accepted and loads completely.
    prog_q.delete();
    for (int i = 0; i < 256; i++) prog_q.push_back($urandom);
    load_prog(prog_sum(), 1);
    checks++;
    if (wr_addr_q.size() != 256) begin
      errors++;
      $display("FAIL len256_nwrites: got %0d expected 256", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[255] !== BASE + 32'd1020 || wr_data_q[255] !== prog_q[255]) begin
        errors++;
        $display("FAIL len256_last: got @%h=%h expected @%h=%h", wr_addr_q[255], wr_data_q[255], BASE + 32'd1020, prog_q[255]);
      end
    end
    checks++;
    if ({done_o, err_o} !== 2'b10) begin
      errors++;
      $display("FAIL len256_status: done/err=%02b expected 10", {done_o, err_o});
    end
  endtask

  task automatic test_random();
    int len;
    bit good;
    logic [31:0] csum;
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 8);
      good = ($urandom_range(0, 3) != 0);
      prog_q.delete();
      for (int i = 0; i < len; i++) prog_q.push_back($urandom);
      csum = prog_sum();
      if (!good) csum = csum ^ (32'h1 << $urandom_range(31, 0));
      load_prog(csum, 3);
      checks++;
      if (wr_addr_q.size() != len) begin
        errors++;
        $display("FAIL rand%0d_nwrites: got %0d expected %0d", t, wr_addr_q.size(), len);
      end else begin
        for (int i = 0; i < len; i++) begin
          checks++;
          if (wr_addr_q[i] !== BASE + 32'(4 * i) || wr_data_q[i] !== prog_q[i]) begin
            errors++;
            $display("FAIL rand%0d_w%0d: got @%h=%h expected @%h=%h", t, i, wr_addr_q[i], wr_data_q[i], BASE + 32'(4 * i), prog_q[i]);
          end
        end
      end
      checks++;
      if ({done_o, start_o, err_o, busy_o} !== {good, good, !good, 1'b0}) begin
        errors++;
        $display("FAIL rand%0d_status: done/start/err/busy=%04b expected %04b", t,
                 {done_o, start_o, err_o, busy_o}, {good, good, !good, 1'b0});
      end
    end
  endtask

  task automatic test_timeout();
    request(LW'(3));
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    repeat (TMO - 1) @(negedge clk_i);
    checks++;
    if ({err_o, busy_o, byte_ready_o} !== 3'b011) begin
      errors++;
      $display("FAIL timeout_early: err/busy/ready=%03b expected 011", {err_o, busy_o, byte_ready_o});
    end
    @(negedge clk_i);
    checks++;
    if ({err_o, busy_o, byte_ready_o} !== 3'b100) begin
      errors++;
      $display("FAIL timeout_abort: err/busy/ready=%03b expected 100", {err_o, busy_o, byte_ready_o});
    end
    prog_q = {32'hCAFE_0001, 32'h1234_5678};
    load_prog(prog_sum(), 2);
    checks++;
    if ({done_o, err_o} !== 2'b10 || wr_addr_q.size() != 2) begin
      errors++;
      $display("FAIL timeout_reload: done/err=%02b writes=%0d expected 10 and 2", {done_o, err_o}, wr_addr_q.size());
    end
  endtask

  task automatic test_async_reset();
    request(LW'(2));
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    checks++;
    if ({busy_o, byte_ready_o} !== 2'b11) begin
      errors++;
      $display("FAIL arst_pre: busy/ready=%02b expected 11", {busy_o, byte_ready_o});
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, busy_o, done_o, err_o, start_o} !== 70'd0) begin
      errors++;
      $display("FAIL arst_clear: busy=%0b ready=%0b done=%0b err=%0b expected all 0", busy_o, byte_ready_o, done_o, err_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    prog_q = {32'h0BAD_F00D};
    load_prog(prog_sum(), 0);
    checks++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== BASE || {done_o, err_o} !== 2'b10) begin
      errors++;
      $display("FAIL arst_reload: writes=%0d done/err=%02b expected 1 write at %h and 10", wr_addr_q.size(), {done_o, err_o}, BASE);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  stream [20];
    logic [31:0] csum;
    int we_cyc[$];
    int k;
    int c;
    bit acc_pending;
    int bad_ready;
    prog_q.delete();
    for (int i = 0; i < 4; i++) prog_q.push_back($urandom);
    csum = prog_sum();
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 4; b++) stream[4*i + b] = prog_q[i][8*b +: 8];
    for (int b = 0; b < 4; b++) stream[16 + b] = csum[8*b +: 8];
    wr_addr_q.delete();
    wr_data_q.delete();
    k = 0;
    acc_pending = 1'b0;
    bad_ready = 0;
    load_req_i = 1'b1;
    len_i = LW'(4);
    byte_valid_i = 1'b1;
    byte_i = stream[0];
    c = 0;
    while (c < 200) begin
      @(negedge clk_i);
      load_req_i = (c == 6);
      len_i = (c == 6) ? LW'(1) : LW'(4);
      if (acc_pending) k++;
      byte_i = (k < 20) ? stream[k] : 8'h00;
      acc_pending = byte_ready_o;
      if (busy_o && (byte_ready_o === imem_we_o)) bad_ready++;
      if (imem_we_o) we_cyc.push_back(c);
      if (done_o || err_o) break;
      c++;
    end
    load_req_i = 1'b0;
    byte_valid_i = 1'b0;
    checks++;
    if (bad_ready != 0) begin
      errors++;
      $display("FAIL b2b_ready: %0d busy cycles with byte_ready_o not the inverse of imem_we_o, expected 0", bad_ready);
    end
    checks++;
    if (we_cyc.size() != 4) begin
      errors++;
      $display("FAIL b2b_nwrites: got %0d expected 4", we_cyc.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (we_cyc[i] - we_cyc[i-1] != 5) begin
          errors++;
          $display("FAIL b2b_spacing%0d: got %0d cycles expected 5", i, we_cyc[i] - we_cyc[i-1]);
        end
      end
      checks++;
      if (wr_addr_q[3] !== BASE + 32'd12 || wr_data_q[3] !== prog_q[3]) begin
        errors++;
        $display("FAIL b2b_w3: got @%h=%h expected @%h=%h", wr_addr_q[3], wr_data_q[3], BASE + 32'd12, prog_q[3]);
      end
    end
    checks++;
    if ({done_o, start_o, err_o} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_status: done/start/err=%03b expected 110", {done_o, start_o, err_o});
    end
  endtask

  initial begin
    test_reset();
    test_t1_good();
    test_t2_bad_csum();
    test_len();
    test_random();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
